// File: rtl/mem_blk_arbiter_if.sv
// Bundle of IC/DC requester, memory-port and status signals for the block
// arbiter.
//   slave  : arbiter view (takes requests and memory responses, drives
//            strobes, completions and returned blocks)
//   master : environment view (requesters plus memory model)
interface mem_blk_arbiter_if;
  logic         i_req;
  logic [31:0]  i_addr;
  logic [255:0] i_rdata;
  logic         i_done;
  logic         d_req;
  logic         d_we;
  logic [31:0]  d_addr;
  logic [255:0] d_wdata;
  logic [255:0] d_rdata;
  logic         d_done;
  logic [31:0]  mem_addr;
  logic         mem_blk_read;
  logic         mem_blk_write;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;
  logic         mem_rd_valid;
  logic         mem_wr_valid;
  logic         busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
           mem_rdata, mem_rd_valid, mem_wr_valid,
    output i_rdata, i_done, d_rdata, d_done,
           mem_addr, mem_blk_read, mem_blk_write, mem_wdata, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
           mem_rdata, mem_rd_valid, mem_wr_valid,
    input  i_rdata, i_done, d_rdata, d_done,
           mem_addr, mem_blk_read, mem_blk_write, mem_wdata, busy
  );
endinterface

// File: rtl/mem_blk_arbiter.sv
// Arbiter for the single main-memory block port, shared by the instruction
// cache (block reads) and the data cache (block reads/writes). Serialises
// transactions, bounds IC starvation and re-issues requests that memory has
// not answered within TIMEOUT cycles.
// Ports:
//   CLK   - clock, rising edge
//   RESET - asynchronous active-low reset
//   bus   - mem_blk_arbiter_if.slave: requester, memory and status signals
// Every output is a decode of, or a copy of, a flop; no input reaches an
// output combinationally.
module mem_blk_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 64
) (
  input logic              CLK,
  input logic              RESET,
  mem_blk_arbiter_if.slave bus
);
  localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);
  localparam logic [7:0] WAIT_MAX = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, RD_I, RD_D, WR_D, RETRY, RESP} state_e;

  state_e       state_q, state_d;
  state_e       op_q, op_d;          // issuing state of the current transaction
  logic [3:0]   streak_q, streak_d;
  logic [7:0]   wait_q, wait_d;
  logic [31:0]  addr_q, addr_d;
  logic [255:0] wdata_q, wdata_d;
  logic [255:0] irdata_q, irdata_d;
  logic [255:0] drdata_q, drdata_d;
  logic         grant_i;
  logic         resp_ok;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= IDLE;
      op_q     <= IDLE;
      streak_q <= '0;
      wait_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      irdata_q <= '0;
      drdata_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      streak_q <= streak_d;
      wait_q   <= wait_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    streak_d = streak_q;
    wait_d   = wait_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    irdata_d = irdata_q;
    drdata_d = drdata_q;
    grant_i  = 1'b0;
    // Only the response matching the strobe type counts; the other is noise.
    resp_ok  = (state_q == WR_D) ? bus.mem_wr_valid : bus.mem_rd_valid;

    unique case (state_q)
      IDLE: begin
        grant_i = bus.i_req && (!bus.d_req || (streak_q == LIMIT));
        if (grant_i) begin
          state_d  = RD_I;
          op_d     = RD_I;
          addr_d   = bus.i_addr & ~32'h1F;
          streak_d = '0;
          wait_d   = '0;
        end else if (bus.d_req) begin
          state_d = bus.d_we ? WR_D : RD_D;
          op_d    = bus.d_we ? WR_D : RD_D;
          addr_d  = bus.d_addr & ~32'h1F;
          wait_d  = '0;
          if (bus.d_we) wdata_d = bus.d_wdata;
          // Only D grants that actually bypass a waiting I count.
          if (bus.i_req && (streak_q != 4'hF)) streak_d = streak_q + 4'd1;
        end
      end
      RD_I, RD_D, WR_D: begin
        if (resp_ok) begin
          state_d = RESP;
          if (state_q == RD_I) irdata_d = bus.mem_rdata;
          if (state_q == RD_D) drdata_d = bus.mem_rdata;
        end else if (wait_q == WAIT_MAX) begin
          state_d = RETRY;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      RETRY: begin
        state_d = op_q;
        wait_d  = '0;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_blk_read  = (state_q == RD_I) || (state_q == RD_D);
  assign bus.mem_blk_write = (state_q == WR_D);
  assign bus.mem_addr      = addr_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.i_done        = (state_q == RESP) && (op_q == RD_I);
  assign bus.d_done        = (state_q == RESP) && (op_q != RD_I);
  assign bus.i_rdata       = irdata_q;
  assign bus.d_rdata       = drdata_q;
  assign bus.busy          = (state_q != IDLE);
endmodule

// File: tb/tb_mem_blk_arbiter.sv
module tb_mem_blk_arbiter;
  localparam int LIM = 4;
  localparam int TMO = 8;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  mem_blk_arbiter_if bus();
  mem_blk_arbiter #(.STARVE_LIMIT(LIM), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Transaction-level model: who owns the port, whether the strobe is up,
  // how long it has been up, and whether a retry gap or completion is showing.
  int           m_own;      // 0 none, 1 IC, 2 DC
  bit           m_wr, m_strobe, m_gap, m_resp;
  int           m_age, m_streak;
  logic [31:0]  m_addr;
  logic [255:0] m_wdata, m_irdata, m_drdata;

  task automatic model_reset();
    m_own = 0; m_wr = 0; m_strobe = 0; m_gap = 0; m_resp = 0;
    m_age = 0; m_streak = 0;
    m_addr = '0; m_wdata = '0; m_irdata = '0; m_drdata = '0;
  endtask

  task automatic model_step();
    if (m_resp) begin
      m_resp = 0; m_own = 0;
    end else if (m_gap) begin
      m_gap = 0; m_strobe = 1; m_age = 0;
    end else if (m_strobe) begin
      if (m_wr ? bus.mem_wr_valid : bus.mem_rd_valid) begin
        if (!m_wr && m_own == 1) m_irdata = bus.mem_rdata;
        if (!m_wr && m_own == 2) m_drdata = bus.mem_rdata;
        m_strobe = 0; m_resp = 1;
      end else if (m_age == TMO - 1) begin
        m_strobe = 0; m_gap = 1;
      end else begin
        m_age++;
      end
    end else if (bus.i_req && (!bus.d_req || m_streak == LIM)) begin
      m_own = 1; m_wr = 0; m_strobe = 1; m_age = 0; m_streak = 0;
      m_addr = {bus.i_addr[31:5], 5'b0};
    end else if (bus.d_req) begin
      m_own = 2; m_wr = bus.d_we; m_strobe = 1; m_age = 0;
      m_addr = {bus.d_addr[31:5], 5'b0};
      if (bus.d_we) m_wdata = bus.d_wdata;
      if (bus.i_req && m_streak < 15) m_streak++;
    end
  endtask

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("busy",       256'(bus.busy),          256'(m_own != 0));
    chk("blk_read",   256'(bus.mem_blk_read),  256'(m_strobe && !m_wr));
    chk("blk_write",  256'(bus.mem_blk_write), 256'(m_strobe && m_wr));
    chk("mem_addr",   256'(bus.mem_addr),      256'(m_addr));
    chk("mem_wdata",  bus.mem_wdata,           m_wdata);
    chk("i_done",     256'(bus.i_done),        256'(m_resp && m_own == 1));
    chk("d_done",     256'(bus.d_done),        256'(m_resp && m_own == 2));
    chk("i_rdata",    bus.i_rdata,             m_irdata);
    chk("d_rdata",    bus.d_rdata,             m_drdata);
  endtask

  // Inputs present now are what the next edge samples; outputs are checked
  // 1 time unit after that edge.
  task automatic tick();
    if (RESET) model_step();
    @(posedge CLK);
    #1;
    compare_all();
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  initial begin
    logic [255:0] pat, apat;
    logic [15:0]  seq;
    logic [9:0]   order;
    logic [31:0]  seen_addr;
    int ns, nd, nw, nr, ng, dpos;

    bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = '0; bus.d_wdata = '0; bus.mem_rdata = '0;
    bus.mem_rd_valid = 0; bus.mem_wr_valid = 0;
    model_reset();

    #2;
    compare_all();
    chk("reset_busy_lit", 256'(bus.busy), 256'(0));
    #10 RESET = 1'b1;
    repeat (2) tick();

    // IC read answered on the 5th strobe cycle
    pat = {8{32'hC0DE_0001}};
    bus.i_req = 1; bus.i_addr = 32'h0040_1234;
    tick();
    ns = 0; nd = 0; seen_addr = '0;
    for (int n = 0; n < 12; n++) begin
      bus.mem_rd_valid = 0;
      if (bus.mem_blk_read) begin
        ns++; seen_addr = bus.mem_addr;
        bus.mem_rd_valid = (ns == 5); bus.mem_rdata = pat;
      end
      if (bus.i_done) begin
        nd++; bus.i_req = 0;
        chk("ic_rdata_lit", bus.i_rdata, {8{32'hC0DE_0001}});
      end
      tick();
    end
    chk("ic_addr_lit",   256'(seen_addr), 256'(32'h0040_1220));
    chk("ic_strobe_cnt", 256'(ns), 256'(5));
    chk("ic_done_cnt",   256'(nd), 256'(1));

    // DC write with stray read-valid pulses
    apat = {32{8'hA5}};
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h2000_0047; bus.d_wdata = apat;
    tick();
    nw = 0; nr = 0; nd = 0;
    for (int n = 0; n < 10; n++) begin
      bus.mem_rd_valid = 0; bus.mem_wr_valid = 0;
      if (bus.mem_blk_read) nr++;
      if (bus.mem_blk_write) begin
        nw++;
        chk("dw_wdata_lit", bus.mem_wdata, {32{8'hA5}});
        bus.mem_rd_valid = (nw < 3); bus.mem_wr_valid = (nw == 3);
      end
      if (bus.d_done) begin nd++; bus.d_req = 0; bus.d_we = 0; end
      tick();
    end
    chk("dw_write_cnt", 256'(nw), 256'(3));
    chk("dw_read_cnt",  256'(nr), 256'(0));
    chk("dw_done_cnt",  256'(nd), 256'(1));

    // Contention: both held high, memory answers immediately
    bus.i_req = 1; bus.i_addr = 32'h1000_0000;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h2000_0000;
    ng = 0; order = '0;
    for (int n = 0; n < 100 && ng < 10; n++) begin
      tick();
      if (bus.mem_blk_read) begin
        order[ng] = (bus.mem_addr[31:28] == 4'h1);
        ng++;
      end
      bus.mem_rd_valid = bus.mem_blk_read;
    end
    bus.i_req = 0; bus.d_req = 0;
    repeat (4) begin tick(); bus.mem_rd_valid = bus.mem_blk_read; end
    bus.mem_rd_valid = 0;
    chk("arb_grants", 256'(ng), 256'(10));
    chk("arb_order_lit", 256'(order), 256'(10'b10_0001_0000));

    // Timeout: 8 strobe cycles, 1 gap, answered on the 3rd re-issue cycle
    bus.i_req = 1; bus.i_addr = 32'h0000_0ABC;
    tick();
    seq = '0; nd = 0;
    for (int n = 0; n < 16; n++) begin
      seq[n] = bus.mem_blk_read;
      if (bus.mem_blk_read && n >= 9)
        chk("tmo_retry_addr_lit", 256'(bus.mem_addr), 256'(32'h0000_0AA0));
      bus.mem_rd_valid = bus.mem_blk_read && (n == 11);
      if (bus.i_done) begin nd++; bus.i_req = 0; end
      tick();
    end
    bus.mem_rd_valid = 0;
    chk("tmo_strobe_seq", 256'(seq), 256'(16'h0EFF));
    chk("tmo_done_cnt",   256'(nd),  256'(1));

    // Response on the wait-limit cycle completes without retry
    bus.i_req = 1; bus.i_addr = 32'h0000_1234;
    tick();
    seq = '0; nd = 0; dpos = -1;
    for (int n = 0; n < 14; n++) begin
      seq[n] = bus.mem_blk_read;
      bus.mem_rd_valid = bus.mem_blk_read && (n == 7);
      if (bus.i_done) begin nd++; dpos = n; bus.i_req = 0; end
      tick();
    end
    bus.mem_rd_valid = 0;
    chk("edge_strobe_seq", 256'(seq),  256'(16'h00FF));
    chk("edge_done_pos",   256'(dpos), 256'(8));
    chk("edge_done_cnt",   256'(nd),   256'(1));

    // Reset in the middle of a DC read, then IC pending
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h3000_0040;
    tick(); tick();
    chk("rst_pre_read", 256'(bus.mem_blk_read), 256'(1));
    #2 RESET = 1'b0;
    model_reset();
    #1;
    compare_all();
    chk("rst_busy_lit",   256'(bus.busy),     256'(0));
    chk("rst_addr_lit",   256'(bus.mem_addr), 256'(0));
    chk("rst_irdata_lit", bus.i_rdata,        256'(0));
    bus.d_req = 0; bus.i_req = 1; bus.i_addr = 32'h0050_0010;
    #1 RESET = 1'b1;
    tick();
    chk("rst_regrant_read_lit", 256'(bus.mem_blk_read), 256'(1));
    chk("rst_regrant_addr_lit", 256'(bus.mem_addr),     256'(32'h0050_0000));
    bus.mem_rd_valid = 1;
    tick();
    bus.mem_rd_valid = 0; bus.i_req = 0;
    repeat (2) tick();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        #2 RESET = 1'b0;
        model_reset();
        #1 compare_all();
        #1 RESET = 1'b1;
      end
      if (m_resp && m_own == 1) bus.i_req = 0;
      else if (!bus.i_req && $urandom_range(3) == 0) begin
        bus.i_req = 1; bus.i_addr = $urandom;
      end
      if (m_resp && m_own == 2) bus.d_req = 0;
      else if (!bus.d_req && $urandom_range(3) == 0) begin
        bus.d_req = 1; bus.d_we = $urandom_range(1);
        bus.d_addr = $urandom; bus.d_wdata = rnd256();
      end
      bus.mem_rdata    = rnd256();
      bus.mem_rd_valid = ($urandom_range(5) == 0);
      bus.mem_wr_valid = ($urandom_range(5) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_blk_arbiter.md
# mem_blk_arbiter

Arbitrates the single main-memory block port between the instruction cache (block reads only) and the data cache (block reads and block writes). It sits between the IC/DC miss engines and the `iBlkRead`/`dBlkRead`/`dBlkWrite` memory interface. It serialises transactions, holds each request stable until memory reports completion, and bounds instruction-fetch starvation. It also re-issues a request that memory has not answered within a timeout.

## Interface
- `STARVE_LIMIT`, 4: consecutive D grants taken while `i_req` is pending; once reached, I wins the next arbitration. Range 1..15.
- `TIMEOUT`, 64: cycles a memory request may stay unanswered before it is retried. Range 2..255.
- `CLK` in 1: the single clock; all state changes on the rising edge.
- `RESET` in 1: asynchronous, active-low reset.
- `i_req` in 1: IC block-read request; held high until `i_done`.
- `i_addr` in 32: IC miss address.
- `i_rdata` out 256: block returned to IC; valid while `i_done`=1.
- `i_done` out 1: one-cycle completion pulse to IC.
- `d_req` in 1: DC request; held high, with `d_we`/`d_addr`/`d_wdata` stable, until `d_done`.
- `d_we` in 1: 1 selects block write, 0 selects block read.
- `d_addr` in 32, `d_wdata` in 256: DC address and write block.
- `d_rdata` out 256: block returned to DC; valid while `d_done`=1.
- `d_done` out 1: one-cycle completion pulse to DC.
- `mem_addr` out 32: block-aligned address; bits [4:0] are always 0.
- `mem_blk_read` out 1, `mem_blk_write` out 1: request strobes to memory; never high together.
- `mem_wdata` out 256: write block.
- `mem_rdata` in 256, `mem_rd_valid` in 1, `mem_wr_valid` in 1: memory responses.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, RD_I, RD_D, WR_D, RETRY, RESP.
- IDLE arbitration:
  - If only one request is pending, it wins.
  - If both are pending, D wins unless `streak`==`STARVE_LIMIT`; in that case I wins.
  - Winner: I goes to RD_I; D goes to RD_D when `d_we`=0, WR_D when `d_we`=1.
- `streak` (4-bit, saturating):
  - Increments on a D grant made while `i_req`=1.
  - Cleared on any I grant.
  - Unchanged on a D grant made while `i_req`=0.
- On grant, the arbiter latches the address (low 5 bits zeroed) and, for writes, `d_wdata`. `mem_*` outputs are driven only from these latches; later requester changes have no effect.
- RD_I / RD_D: `mem_blk_read`=1.
  - On `mem_rd_valid`=1, capture `mem_rdata` into the owner's rdata register and go to RESP.
  - `mem_wr_valid` is ignored in these states.
- WR_D: `mem_blk_write`=1.
  - On `mem_wr_valid`=1, go to RESP.
  - `mem_rd_valid` is ignored in this state.
- Timeout: an 8-bit `wait_cnt` is cleared on entry to RD_*/WR_D and increments each cycle with no valid response. When it reaches `TIMEOUT`-1 with still no response, go to RETRY.
- RETRY: both strobes are 0 for exactly one cycle, then the FSM re-enters the same RD_I/RD_D/WR_D state with the same latched address and data.
- RESP: the owner's done=1 for one cycle; the next state is always IDLE. Because of this state the requester's dropped `req` is never re-sampled as a new request.
- Reset (asynchronous assertion at any time, including mid-transaction):
  - State goes to IDLE, `streak`=0, `wait_cnt`=0.
  - All outputs go to 0, including strobes, `mem_addr`, `mem_wdata`, both rdata registers, both dones and `busy`.
  - An in-flight transaction is abandoned; it is not resumed after reset.

## Timing
- Request seen in IDLE at cycle 0 → state and strobe high from cycle 1.
- Valid response sampled at cycle k → done=1 at cycle k+1 → IDLE at k+2 → earliest next strobe at k+3.
- Minimum transaction occupancy is 3 cycles (memory answers in the first strobe cycle).
- A response arriving in the same cycle that `wait_cnt` hits its limit counts as success; no retry.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- rdata holds its last captured value after done deasserts, until the next capture for that requester.

## Test plan
- IC read only: `i_req`=1, `i_addr`=0x0040_1234; memory answers 5 cycles after the strobe → `mem_addr`=0x0040_1220, `mem_blk_read`=1 for 5 cycles, one `i_done` pulse, `i_rdata` equals `mem_rdata`.
- DC write: `d_we`=1, `d_wdata`=pattern A5.. → `mem_blk_write`=1 with `mem_wdata`=pattern; `mem_rd_valid` pulses in WR_D are ignored; `mem_wr_valid` → one `d_done` pulse.
- Contention with `STARVE_LIMIT`=4: `i_req` and `d_req` held high continuously → grant order D,D,D,D,I,D,D,D,D,I.
- Timeout with `TIMEOUT`=8 and no response → strobe high 8 cycles, low 1 cycle, high again with the same `mem_addr`; a response on the 3rd retry cycle completes normally.
- Reset asserted mid-RD_D → same cycle, all outputs 0 and `busy`=0; after release with `i_req` pending, I is granted.
- Simultaneous `mem_rd_valid` and timeout-limit cycle → completes, no RETRY.
